double_tokens_arbiter: RTL and testbench
========================================

DOUBLE_TOKENS_ARBITER -- requirements
Module: double_tokens_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2: number of serial requesters.
REQ-002 The block SHALL have parameter MAX_RUN, default 200: maximum pending doubled tokens before overflow.
REQ-003 The block SHALL have parameter CNT_W, default 8: pending-counter width; MAX_RUN+1 must fit in CNT_W bits.
REQ-004 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, N_REQ: per-requester burst request, level, held until granted.
REQ-007 The block SHALL have port a, input, N_REQ: per-requester serial token stream; only the granted bit is used.
REQ-008 The block SHALL have port last, input, N_REQ: marks the final bit of the granted burst.
REQ-009 The block SHALL have port gnt, output, N_REQ: one-hot grant, registered.
REQ-010 The block SHALL have port b, output, 1: shared doubled serial output.
REQ-011 The block SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-012 The block SHALL have port overflow, output, 1: sticky global overflow.
REQ-013 The block SHALL have port ovf_src, output, N_REQ: sticky per-requester overflow cause.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, STREAM and DRAIN.
REQ-015 In IDLE with any req high, the arbiter SHALL pick a winner, register gnt one-hot and enter STREAM on the next edge; with no req, it SHALL stay in IDLE.
REQ-016 Default arbitration SHALL be round-robin: search starts at the index after the previous winner; the pointer updates only on grant.
REQ-017 In STREAM, b SHALL be combinational: a[win] OR (cnt != 0).
REQ-018 In STREAM, cnt SHALL increment on a[win]=1 and decrement on a[win]=0 with cnt>0; otherwise hold.
REQ-019 When last[win]=1 in STREAM and the post-update cnt is nonzero, the FSM SHALL enter DRAIN; when it is zero, the FSM SHALL enter IDLE. gnt SHALL clear on the same edge.
REQ-020 In DRAIN, b SHALL be 1 and cnt SHALL decrement each cycle; the FSM SHALL enter IDLE on the edge where cnt goes 1->0.
REQ-021 In IDLE, b SHALL be 0 and gnt SHALL be 0.
REQ-022 An a=1 arriving at cnt==MAX_RUN SHALL leave cnt at MAX_RUN, set overflow and set ovf_src[win] on that edge. Both are sticky until reset; the burst continues normally.
REQ-023 A 1-bit burst (last in the first STREAM cycle) SHALL be legal.
REQ-024 At least one IDLE cycle SHALL separate consecutive bursts; req changes during STREAM or DRAIN SHALL be ignored until IDLE.
REQ-025 last on a non-granted index SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, cnt=0, gnt=0, overflow=0, ovf_src=0 and RR pointer to N_REQ-1, so req[0] wins first; b and busy SHALL then read 0.
REQ-027 Reset mid-STREAM or mid-DRAIN SHALL abort the burst with no further doubled output.

Configuration
REQ-028 With DOUBLE_TOKENS_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the RR pointer SHALL be absent; without it, arbitration SHALL be round-robin per REQ-016.

Structure
REQ-029 Package double_tokens_arb_pkg SHALL hold the state enum (IDLE, STREAM, DRAIN) and default MAX_RUN/CNT_W constants.
REQ-030 Winner selection SHALL be a sub-module rr_arbiter (req vector in, one-hot out, advance strobe); FSM, counter and flags stay in the top.

Verification
REQ-031 The bench SHALL cover: reset; req=2'b01; a[0]=1,0,0,1 with last on bit 4 -> b=1,1,0,1 then DRAIN b=1 one cycle; gnt=2'b01 for 4 cycles; busy for 5 cycles.
REQ-032 The bench SHALL cover: req=2'b11 held across three bursts -> grants 01, 10, 01 (round-robin); with DOUBLE_TOKENS_FIXED_PRIO_EN -> 01, 01, 01.
REQ-033 The bench SHALL cover: 200 consecutive ones on req[1] then last -> overflow=0, DRAIN lasts 200 cycles; repeat with 201 ones -> overflow=1, ovf_src=2'b10, DRAIN 200 cycles.
REQ-034 The bench SHALL cover: 1-bit burst a=1 with last -> b=1 in STREAM, b=1 one DRAIN cycle, then IDLE with b=0.
REQ-035 The bench SHALL cover: rst_n pulsed low mid-DRAIN with cnt=5 -> gnt, b, busy and cnt=0 immediately; overflow cleared; next grant goes to req[0].
REQ-036 The bench SHALL cover: last asserted on non-granted index 1 while gnt=2'b01 -> no state change.

Source files
------------

// File: rtl/double_tokens_arb_pkg.sv
// Shared types and defaults for the doubled-token arbiter.
// Holds the FSM state encoding and default sizing constants.
package double_tokens_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int MAX_RUN_DEF = 200;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/double_tokens_arbiter_rr.sv
// Winner selection for the doubled-token arbiter: one-hot grant plus index.
// DOUBLE_TOKENS_FIXED_PRIO_EN selects lowest-index priority with no pointer.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

`ifdef DOUBLE_TOKENS_FIXED_PRIO_EN

    logic found;
    wire  unused_ok = ^{clk, rst_n, adv};

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
    end

`else

    logic [IW-1:0] ptr;
    logic          found;
    int            k_idx;

    // Search starts one past the previous winner.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k_idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            k_idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[k_idx]) begin
                gnt[k_idx] = 1'b1;
                idx        = IW'(k_idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N_REQ - 1);
        end else if (adv && found) begin
            ptr <= idx;
        end
    end

`endif

endmodule

// File: rtl/double_tokens_arbiter.sv
// Arbitrates serial requesters onto one doubled-token output stream.
// Build option: DOUBLE_TOKENS_FIXED_PRIO_EN (fixed priority arbitration).
module double_tokens_arbiter
    import double_tokens_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int MAX_RUN = MAX_RUN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a,
    input  logic [N_REQ-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic             b,
    output logic             busy,
    output logic             overflow,
    output logic [N_REQ-1:0] ovf_src
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [IW-1:0]    win;
    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             adv;
    logic             ovf_hit;
    logic             a_w;
    logic             last_w;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (adv),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    assign a_w    = a[win];
    assign last_w = last[win];
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        b        = 1'b0;
        adv      = 1'b0;
        ovf_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    adv      = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                b = a_w | (cnt != '0);
                if (a_w) begin
                    if (cnt == CNT_W'(MAX_RUN)) begin
                        ovf_hit = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end
                // Decision uses the post-update pending count.
                if (last_w) begin
                    state_nx = (cnt_nx != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                b      = 1'b1;
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            win   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (adv) begin
                gnt <= arb_gnt;
                win <= arb_idx;
            end else if (state == STREAM && last_w) begin
                gnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            ovf_src  <= '0;
        end else if (ovf_hit) begin
            overflow <= 1'b1;
            ovf_src  <= ovf_src | gnt;
        end
    end

endmodule

// File: tb/tb_double_tokens_arbiter.sv
// Scoreboard bench for double_tokens_arbiter with a burst-level model.
// Driver queues expected per-cycle outputs; a negedge monitor checks them.
module tb_double_tokens_arbiter;

    localparam int N  = 2;
    localparam int MR = 200;

    typedef struct packed {
        logic [N-1:0] g;
        logic         b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] last = '0;
    logic [N-1:0] gnt;
    logic         b;
    logic         busy;
    logic         overflow;
    logic [N-1:0] ovf_src;

    exp_t         q[$];
    bit           bits[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           m_ptr;
    logic         m_ovf;
    logic [N-1:0] m_src;

    always #5 clk = ~clk;

    double_tokens_arbiter #(
        .N_REQ   (N),
        .MAX_RUN (MR),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a        (a),
        .last     (last),
        .gnt      (gnt),
        .b        (b),
        .busy     (busy),
        .overflow (overflow),
        .ovf_src  (ovf_src)
    );

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Winner choice straight from the arbitration rule.
    function automatic int pick(input logic [N-1:0] rq);
        int w;
        w = -1;
`ifdef DOUBLE_TOKENS_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--)
            if (rq[i]) w = i;
`else
        for (int k = N; k >= 1; k--)
            if (rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (q.size() == 0) begin
                    check("extra_busy_cycle", 32'(busy), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("gnt", 32'(gnt), 32'(e.g));
                    check("b", 32'(b), 32'(e.b));
                end
            end else begin
                check("idle_b", 32'(b), 0);
                check("idle_gnt", 32'(gnt), 0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_b", 32'(b), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ovf_src", 32'(ovf_src), 0);
        check("rst_cnt", 32'(dut.cnt), 0);
        q.delete();
        m_ptr = N - 1;
        m_ovf = 1'b0;
        m_src = '0;
        req = '0;
        a = '0;
        last = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Plays one burst from the global bits queue.
    task automatic run_burst(input logic [N-1:0] rq,
                             input bit abort_drain);
        int   w;
        int   pend;
        int   t;
        exp_t e;
        pend = 0;
        req  = rq;
        a    = '0;
        last = '0;
        w    = pick(rq);
        m_ptr = w;
        foreach (bits[i]) begin
            e.g = N'(1) << w;
            e.b = bits[i] || (pend > 0);
            q.push_back(e);
            if (bits[i]) begin
                if (pend == MR) begin
                    m_ovf = 1'b1;
                    m_src[w] = 1'b1;
                end else begin
                    pend++;
                end
            end else if (pend > 0) begin
                pend--;
            end
        end
        for (int p = 0; p < pend; p++) begin
            e.g = '0;
            e.b = 1'b1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        foreach (bits[i]) begin
            a       = N'($urandom);
            a[w]    = bits[i];
            last    = N'($urandom);
            last[w] = (i == bits.size() - 1);
            @(posedge clk);
            #1;
        end
        a    = '0;
        last = '0;
        if (abort_drain) begin
            check("drain_cnt", 32'(dut.cnt), 32'(pend));
            return;
        end
        t = 0;
        while (busy && t < MR + 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busy) check("drain_timeout", 32'(busy), 0);
        check("queue_left", 32'(q.size()), 0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("ovf_src", 32'(ovf_src), 32'(m_src));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Held double request across three bursts.
        for (int r = 0; r < 3; r++) begin
            bits = '{1'b1, 1'b0};
            run_burst(2'b11, 1'b0);
        end
        req = '0;
        do_reset();

        bits = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_burst(2'b01, 1'b0);
        req = '0;
        @(posedge clk);
        #1;

        bits = '{1'b1};
        run_burst(2'b01, 1'b0);
        req = '0;
        @(posedge clk);
        #1;

        bits.delete();
        repeat (MR) bits.push_back(1'b1);
        run_burst(2'b10, 1'b0);
        req = '0;
        @(posedge clk);
        #1;
        check("no_ovf_at_max", 32'(overflow), 0);

        bits.delete();
        repeat (MR + 1) bits.push_back(1'b1);
        run_burst(2'b10, 1'b0);
        req = '0;
        @(posedge clk);
        #1;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_src_set", 32'(ovf_src), 32'(2'b10));

        bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_burst(2'b10, 1'b1);
        do_reset();
        bits = '{1'b0, 1'b1};
        run_burst(2'b11, 1'b0);
        req = '0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 150; n++) begin
            int len;
            int bias;
            len  = $urandom_range(1, 12);
            bias = $urandom_range(1, 3);
            bits.delete();
            for (int i = 0; i < len; i++)
                bits.push_back(($urandom_range(0, 3) < bias));
            run_burst(N'($urandom_range(1, 3)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                req = '0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        req = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
